// File: rtl/countdown_timer.sv
// mm:ss.cc countdown timer: debounced keys, 10 ms tick, BCD borrow chain,
// SET/RUN/PAUSE/ALARM mode FSM with registered digit and LED outputs.
module countdown_timer_key #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         s1_q, s2_q, deb_q;
  logic [W-1:0] cnt_q;
  logic         accept;

  assign accept  = (s2_q != deb_q) && (cnt_q == LAST);
  assign press_o = accept && !s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q <= key_i;
      s2_q <= s1_q;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end
endmodule

module countdown_timer #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PRESET_MIN      = 1,
  parameter int ALARM_TICKS     = 1000,
  parameter int BLINK_TICKS     = 25
) (
  input  logic       CLOCK_50,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] min_high,
  output logic [3:0] min_low,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic [3:0] cs_high,
  output logic [3:0] cs_low,
  output logic [1:0] edit_field,
  output logic       led_run,
  output logic       led_pause,
  output logic       led_alarm
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [3:0] PMH = 4'(PRESET_MIN / 10);
  localparam logic [3:0] PML = 4'(PRESET_MIN % 10);

  typedef enum logic [1:0] {
    S_SET, S_RUN, S_PAUSE, S_ALARM
  } state_e;

  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = key_reset;

  logic pr_start, pr_mode, pr_inc;
  logic p_start, p_mode, p_inc, p_any;

  countdown_timer_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk(clk), .rst_n(rst_n), .key_i(key_start_pause), .press_o(pr_start)
  );
  countdown_timer_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk(clk), .rst_n(rst_n), .key_i(key_mode), .press_o(pr_mode)
  );
  countdown_timer_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk(clk), .rst_n(rst_n), .key_i(key_inc), .press_o(pr_inc)
  );

  assign p_start = pr_start;
  assign p_mode  = pr_mode & ~pr_start;
  assign p_inc   = pr_inc & ~pr_start & ~pr_mode;
  assign p_any   = pr_start | pr_mode | pr_inc;

  state_e        state_q;
  logic [3:0]    mh_q, ml_q, sh_q, sl_q, ch_q, cl_q;
  logic [3:0]    smh_q, sml_q, ssh_q, ssl_q;
  logic [1:0]    edit_q;
  logic          run_q, pause_q, alarm_q;
  logic [TW-1:0] tick_q;
  logic [AW-1:0] acnt_q;
  logic [BW-1:0] bcnt_q;

  logic tick, counting, is_zero;
  assign counting = (state_q == S_RUN) || (state_q == S_ALARM);
  assign tick     = counting && (tick_q == TW'(TICK_DIV - 1));
  assign is_zero  = {mh_q, ml_q, sh_q, sl_q, ch_q, cl_q} == 24'h0;

  logic [3:0] dmh, dml, dsh, dsl, dch, dcl;
  logic       dzero;

  // Borrow ripples only while the lower digit is already zero.
  always_comb begin
    {dmh, dml, dsh, dsl, dch, dcl} = {mh_q, ml_q, sh_q, sl_q, ch_q, cl_q};
    if (cl_q != 4'd0) begin
      dcl = cl_q - 4'd1;
    end else begin
      dcl = 4'd9;
      if (ch_q != 4'd0) begin
        dch = ch_q - 4'd1;
      end else begin
        dch = 4'd9;
        if (sl_q != 4'd0) begin
          dsl = sl_q - 4'd1;
        end else begin
          dsl = 4'd9;
          if (sh_q != 4'd0) begin
            dsh = sh_q - 4'd1;
          end else begin
            dsh = 4'd5;
            if (ml_q != 4'd0) begin
              dml = ml_q - 4'd1;
            end else begin
              dml = 4'd9;
              dmh = mh_q - 4'd1;
            end
          end
        end
      end
    end
    dzero = {dmh, dml, dsh, dsl, dch, dcl} == 24'h0;
  end

  logic [3:0] ish, isl, imh, iml;

  always_comb begin
    ish = sh_q;
    isl = sl_q + 4'd1;
    if (sl_q == 4'd9) begin
      isl = 4'd0;
      ish = (sh_q == 4'd5) ? 4'd0 : sh_q + 4'd1;
    end
    imh = mh_q;
    iml = ml_q + 4'd1;
    if (ml_q == 4'd9) begin
      iml = 4'd0;
      imh = (mh_q == 4'd9) ? 4'd0 : mh_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SET;
      {mh_q, ml_q} <= {PMH, PML};
      {sh_q, sl_q, ch_q, cl_q} <= 16'h0;
      {smh_q, sml_q} <= {PMH, PML};
      {ssh_q, ssl_q} <= 8'h0;
      edit_q  <= 2'd1;
      run_q   <= 1'b0;
      pause_q <= 1'b0;
      alarm_q <= 1'b0;
      tick_q  <= '0;
      acnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      if (!counting || tick) tick_q <= '0;
      else                   tick_q <= tick_q + TW'(1);

      unique case (state_q)
        S_SET: begin
          unique case (1'b1)
            p_start: begin
              if (!is_zero) begin
                {smh_q, sml_q, ssh_q, ssl_q} <= {mh_q, ml_q, sh_q, sl_q};
                state_q <= S_RUN;
                run_q   <= 1'b1;
                edit_q  <= 2'd0;
                tick_q  <= '0;
              end
            end
            p_mode: edit_q <= (edit_q == 2'd1) ? 2'd2 : 2'd1;
            p_inc: begin
              if (edit_q == 2'd2) {mh_q, ml_q} <= {imh, iml};
              else                {sh_q, sl_q} <= {ish, isl};
            end
            default: ;
          endcase
        end
        S_RUN: begin
          if (p_start) begin
            state_q <= S_PAUSE;
            run_q   <= 1'b0;
            pause_q <= 1'b1;
          end else if (tick) begin
            {mh_q, ml_q, sh_q, sl_q, ch_q, cl_q} <=
              {dmh, dml, dsh, dsl, dch, dcl};
            if (dzero) begin
              state_q <= S_ALARM;
              run_q   <= 1'b0;
              alarm_q <= 1'b1;
              acnt_q  <= '0;
              bcnt_q  <= '0;
            end
          end
        end
        S_PAUSE: begin
          if (p_start) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
            pause_q <= 1'b0;
            tick_q  <= '0;
          end else if (p_mode) begin
            state_q <= S_SET;
            pause_q <= 1'b0;
            edit_q  <= 2'd1;
            {mh_q, ml_q, sh_q, sl_q} <= {smh_q, sml_q, ssh_q, ssl_q};
            {ch_q, cl_q} <= 8'h0;
          end
        end
        S_ALARM: begin
          if (p_any || (tick && acnt_q == AW'(ALARM_TICKS - 1))) begin
            state_q <= S_SET;
            alarm_q <= 1'b0;
            edit_q  <= 2'd1;
            {mh_q, ml_q, sh_q, sl_q} <= {smh_q, sml_q, ssh_q, ssl_q};
            {ch_q, cl_q} <= 8'h0;
          end else if (tick) begin
            acnt_q <= acnt_q + AW'(1);
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
              bcnt_q  <= '0;
              alarm_q <= ~alarm_q;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
            end
          end
        end
        default: state_q <= S_SET;
      endcase
    end
  end

  assign min_high   = mh_q;
  assign min_low    = ml_q;
  assign sec_high   = sh_q;
  assign sec_low    = sl_q;
  assign cs_high    = ch_q;
  assign cs_low     = cl_q;
  assign edit_field = edit_q;
  assign led_run    = run_q;
  assign led_pause  = pause_q;
  assign led_alarm  = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: SET-mode vector table, cycle-exact countdown
// scoreboard, pause/alarm/priority/reset sequences.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] keys = 3'b111;
  logic [3:0] mh, ml, sh, sl, ch, cl;
  logic [1:0] edit;
  logic       lrun, lpause, lalarm;
  int         cyc_n = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  localparam logic [2:0] K_START = 3'b001;
  localparam logic [2:0] K_MODE  = 3'b010;
  localparam logic [2:0] K_INC   = 3'b100;
  localparam logic [4:0] ST_SET1 = 5'h08;
  localparam logic [4:0] ST_SET2 = 5'h10;
  localparam logic [4:0] ST_RUN  = 5'h04;
  localparam logic [4:0] ST_PAU  = 5'h02;
  localparam logic [4:0] ST_AL1  = 5'h01;

  countdown_timer #(
    .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .PRESET_MIN(1),
    .ALARM_TICKS(20), .BLINK_TICKS(5)
  ) dut (
    .CLOCK_50(clk), .key_reset(rst_n),
    .key_start_pause(keys[0]), .key_mode(keys[1]), .key_inc(keys[2]),
    .min_high(mh), .min_low(ml), .sec_high(sh), .sec_low(sl),
    .cs_high(ch), .cs_low(cl), .edit_field(edit),
    .led_run(lrun), .led_pause(lpause), .led_alarm(lalarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [23:0] d;
    logic [4:0]  s;
  } exp_t;

  typedef struct {
    logic [2:0]  mask;
    int          cnt;
    logic [23:0] d;
    logic [4:0]  s;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[7];

  function automatic logic [23:0] dig();
    return {mh, ml, sh, sl, ch, cl};
  endfunction

  function automatic logic [4:0] st();
    return {edit, lrun, lpause, lalarm};
  endfunction

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [4:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    e = exp_q.pop_front();
    chk({nm, "_digits"}, 32'(dig()), 32'(e.d));
    chk({nm, "_status"}, 32'(st()), 32'(e.s));
  endtask

  task automatic wait_st(input logic [4:0] exp, input int lim,
                         input string nm, output int t);
    int i;
    i = 0;
    while (st() !== exp && i < lim) begin
      cyc(1);
      i++;
    end
    n_cmp++;
    if (st() !== exp) begin
      n_err++;
      $display("FAIL %s: status %h expected %h (timeout)", nm, st(), exp);
    end
    t = cyc_n;
  endtask

  task automatic apply(input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      keys = keys & ~m;
      cyc(6);
      keys = keys | m;
      cyc(6);
    end
  endtask

  initial begin
    int t0, t1, tp, ta, tb, ticks;
    tbl[0] = '{K_INC,   59, 24'h015900, ST_SET1};
    tbl[1] = '{K_INC,    1, 24'h010000, ST_SET1};
    tbl[2] = '{K_MODE,   1, 24'h010000, ST_SET2};
    tbl[3] = '{K_INC,   99, 24'h000000, ST_SET2};
    tbl[4] = '{K_START,  1, 24'h000000, ST_SET2};
    tbl[5] = '{K_MODE,   1, 24'h000000, ST_SET1};
    tbl[6] = '{K_INC,    1, 24'h000100, ST_SET1};

    cyc(3);
    chk("reset_digits", 32'(dig()), 32'h010000);
    chk("reset_status", 32'(st()), 32'(ST_SET1));
    rst_n = 1'b1;
    cyc(2);
    keys = ~K_INC;
    cyc(2);
    keys = 3'b111;
    cyc(10);
    chk("glitch_digits", 32'(dig()), 32'h010000);

    foreach (tbl[i]) begin
      apply(tbl[i].mask, tbl[i].cnt);
      push(tbl[i].d, tbl[i].s);
      pop_cmp($sformatf("vec%0d", i));
    end

    keys = ~K_START;
    wait_st(ST_RUN, 20, "run_entry", t0);
    chk("run_entry_digits", 32'(dig()), 32'h000100);
    cyc(3);
    chk("pre_tick_digits", 32'(dig()), 32'h000100);
    cyc(1);
    chk("first_tick_digits", 32'(dig()), 32'h000099);
    keys = 3'b111;
    for (int k = 2; k <= 100; k++) begin
      cyc(4);
      push(to_bcd(100 - k), (k == 100) ? ST_AL1 : ST_RUN);
      pop_cmp($sformatf("tick%0d", k));
    end

    cyc(19);
    chk("blink_19", 32'(lalarm), 32'd1);
    cyc(1);
    chk("blink_20", 32'(lalarm), 32'd0);
    cyc(20);
    chk("blink_40", 32'(lalarm), 32'd1);
    cyc(20);
    chk("blink_60", 32'(lalarm), 32'd0);
    cyc(19);
    chk("alarm_79_digits", 32'(dig()), 32'h000000);
    chk("alarm_79_status", 32'(st()), 32'h00);
    cyc(1);
    chk("alarm_end_digits", 32'(dig()), 32'h000100);
    chk("alarm_end_status", 32'(st()), 32'(ST_SET1));

    apply(K_MODE, 1);
    apply(K_INC, 10);
    apply(K_MODE, 1);
    apply(K_INC, 59);
    chk("set10_digits", 32'(dig()), 32'h100000);
    chk("set10_status", 32'(st()), 32'(ST_SET1));

    keys = ~K_START;
    wait_st(ST_RUN, 20, "run10_entry", t0);
    cyc(4);
    chk("run10_tick1", 32'(dig()), 32'h095999);
    keys = 3'b111;
    cyc(8);
    keys = ~K_START;
    wait_st(ST_PAU, 20, "pause_entry", tp);
    keys = 3'b111;
    ticks = (tp - t0 - 1) / 4;
    for (int i = 0; i < 4; i++) begin
      cyc(10);
      chk($sformatf("pause_frozen%0d", i), 32'(dig()),
          32'(to_bcd(60000 - ticks)));
    end
    keys = ~K_START;
    wait_st(ST_RUN, 20, "resume", t1);
    keys = 3'b111;
    cyc(8);
    keys = ~K_START;
    wait_st(ST_PAU, 20, "pause2", tp);
    keys = 3'b111;
    ticks = ticks + (tp - t1 - 1) / 4;
    chk("pause2_digits", 32'(dig()), 32'(to_bcd(60000 - ticks)));
    cyc(8);
    apply(K_MODE, 1);
    chk("restore_digits", 32'(dig()), 32'h100000);
    chk("restore_status", 32'(st()), 32'(ST_SET1));

    apply(K_MODE, 1);
    apply(K_INC, 90);
    chk("set0_digits", 32'(dig()), 32'h000000);
    apply(K_MODE, 1);
    apply(K_INC, 1);
    keys = ~K_START;
    wait_st(ST_RUN, 20, "run1s_entry", t0);
    keys = 3'b111;
    wait_st(ST_AL1, 500, "alarm2_entry", ta);
    chk("alarm2_len", 32'(ta - t0), 32'd400);
    cyc(12);
    keys = ~K_MODE;
    wait_st(ST_SET1, 20, "alarm_abort", tb);
    keys = 3'b111;
    chk("abort_latency", 32'(tb - ta), 32'd17);
    chk("abort_digits", 32'(dig()), 32'h000100);
    cyc(8);

    keys = ~K_START;
    wait_st(ST_RUN, 20, "run_prio", t0);
    keys = 3'b111;
    cyc(8);
    keys = ~(K_START | K_INC);
    wait_st(ST_PAU, 20, "prio_pause", tp);
    keys = 3'b111;
    ticks = (tp - t0 - 1) / 4;
    chk("prio_digits", 32'(dig()), 32'(to_bcd(100 - ticks)));
    cyc(8);
    chk("prio_hold_digits", 32'(dig()), 32'(to_bcd(100 - ticks)));
    chk("prio_hold_status", 32'(st()), 32'(ST_PAU));

    keys = ~K_START;
    wait_st(ST_RUN, 20, "run_rst", t1);
    keys = 3'b111;
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(dig()), 32'h010000);
    chk("async_rst_status", 32'(st()), 32'(ST_SET1));
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("post_rst_digits", 32'(dig()), 32'h010000);
    chk("post_rst_status", 32'(st()), 32'(ST_SET1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Count-down counterpart of the lab stopwatch: the user sets an mm:ss value, and the block decrements it in 10 ms steps down to 00:00.00, then raises a blinking alarm.
- Owns key conditioning (sync + debounce + press detect), the 10 ms tick, the BCD borrow chain and the mode FSM.
- Drives six BCD digits that the top level routes to the existing seven-segment decoders (hex5..hex0), plus status LEDs.

Parameters:
TICK_DIV, 500000, CLOCK_50 cycles per 10 ms tick
DEBOUNCE_CYCLES, 1000000, cycles a raw key must hold a new level before it is accepted (20 ms)
PRESET_MIN, 1, minutes value loaded at reset (0..99); seconds and centiseconds preset to 0
ALARM_TICKS, 1000, ticks the alarm lasts before auto-return to SET (10 s)
BLINK_TICKS, 25, ticks per led_alarm toggle

Ports:
CLOCK_50  in  1  system clock
key_reset  in  1  asynchronous, active-low reset
key_start_pause  in  1  raw pushbutton, active-low
key_mode  in  1  raw pushbutton, active-low; selects edit field / returns to SET
key_inc  in  1  raw pushbutton, active-low; increments the selected field
min_high, min_low, sec_high, sec_low, cs_high, cs_low  out  4 each  BCD digits of current value
edit_field  out  2  0 = none, 1 = seconds, 2 = minutes
led_run  out  1  high in RUN
led_pause  out  1  high in PAUSE
led_alarm  out  1  blinking in ALARM, else 0

Behaviour:
- Reset (key_reset low, async): state = SET, value = PRESET_MIN:00.00, saved value = same, edit_field = 1, all LEDs 0, tick/debounce/blink counters 0, debounced key levels = 1 (released).
- Key conditioning per key:
  - 2-FF synchroniser.
  - Debounced level changes only after the synced input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Press = one-cycle pulse on the debounced 1->0 transition. A release produces no event.
- Simultaneous presses in one cycle: only the highest-priority one is acted on (start_pause > mode > inc); the others are dropped.
- Tick:
  - Counter runs only in RUN and ALARM; tick pulse when count == TICK_DIV-1, then count wraps to 0.
  - Counter is cleared on every transition into RUN, so the first decrement lands exactly TICK_DIV cycles after the transition cycle.
- FSM SET:
  - edit_field is 1 or 2. mode press toggles 1<->2.
  - inc press on seconds: sec = (sec+1) mod 60, no carry into minutes. inc press on minutes: min = (min+1) mod 100.
  - cs digits held at 0.
  - start press: if value != 0, copy value to saved value and enter RUN; if value == 0, ignore.
- FSM RUN:
  - led_run = 1, edit_field = 0.
  - Each tick decrements value by 1 cs. Borrow chain: cs_low 0->9, cs_high 0->9, sec_low 0->9, sec_high 0->5, min_low 0->9, then min_high is decremented.
  - If the decrement result is 00:00.00, enter ALARM in the same cycle that the zero is written. The value never underflows.
  - start press enters PAUSE. mode and inc presses are ignored.
- FSM PAUSE:
  - led_pause = 1, value frozen, edit_field = 0.
  - start press enters RUN.
  - mode press enters SET with value = saved value and edit_field = 1.
  - inc press is ignored.
- FSM ALARM:
  - value = 0. led_alarm = 1 on entry and toggles every BLINK_TICKS ticks.
  - After ALARM_TICKS ticks, or on any key press, enter SET with value = saved value, edit_field = 1, led_alarm = 0.
- Asserting reset mid-countdown aborts immediately to the reset state. The saved value is lost and returns to the preset.
- Digits are registered outputs that change only on the state/value update edge; there are no combinational paths from the keys.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, ALARM_TICKS=20, BLINK_TICKS=5):
1. Reset, then release -> digits 01:00.00, edit_field=1, led_run/led_pause/led_alarm all 0. A 2-cycle glitch on key_inc leaves the value unchanged.
2. SET with sec=59: press inc -> 01:00.00 (minutes unchanged). Press mode, then inc 99 times from 01 -> 00:00.00. Press start -> stays in SET.
3. Set 00:01.00 and press start -> 00:00.99 appears 4 cycles after the start-press cycle. After 100 ticks -> 00:00.00 with led_alarm=1 on the same edge.
4. Run from 10:00.00 for one tick -> 09:59.99. Press start -> PAUSE, value frozen for 40 cycles. Press start -> RUN resumes. Press start, then mode -> SET showing 10:00.00.
5. ALARM: led_alarm toggles every 5 ticks; after 20 ticks -> SET showing the saved value. Repeat, with a mode press at tick 3 -> immediate return to SET.
6. Press start and inc in the same cycle during RUN -> PAUSE only, value unchanged. Assert key_reset mid-RUN -> 01:00.00, state SET, with no stale tick.
